mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter W_DATA, 32, data and address width; the byte-lane rules below require 32.
REQ-002 Parameter TMO_CYC, 255, bus watchdog limit in cycles; used only when MEM_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ex_alu_r  input  W_DATA  ALU result from execute; this is the memory byte address for loads and stores.
REQ-006 ex_store_data  input  W_DATA  store operand (rt).
REQ-007 ex_jalra  input  W_DATA  link address.
REQ-008 ex_c_wb_src  input  2  writeback source select, passed through.
REQ-009 ex_c_mem_rd / ex_c_mem_wr / ex_c_mem_byte  input  1 each  load, store, byte-size qualifier (lbu/sb).
REQ-010 stall  output  1  holds execute and earlier stages.
REQ-011 bus_req, bus_we  output  1 each  bus request, write enable.
REQ-012 bus_addr, bus_wdata  output  W_DATA each  word-aligned address, write data.
REQ-013 bus_ack  input  1  one-cycle completion strobe; bus_rdata  input  W_DATA  read data, valid with bus_ack.
REQ-014 data_word, jalra, alu_r  output  W_DATA each  registered values for writeback.
REQ-015 lbu_byte  output  2  registered byte offset for writeback.
REQ-016 c_wb_src  output  2  registered writeback select.
REQ-017 bus_err  output  1  one-cycle watchdog abort pulse.

Function
REQ-018 FSM states: IDLE, RD, WR, RMW_RD, RMW_WR.
REQ-019 In IDLE with no memory op, the edge captures ex_alu_r, ex_jalra, ex_c_wb_src and ex_alu_r[1:0] into alu_r, jalra, c_wb_src and lbu_byte. Latency: 1 cycle. stall=0.
REQ-020 In IDLE, the next state is decided in this order: ex_c_mem_wr with ex_c_mem_byte goes to RMW_RD; ex_c_mem_wr alone goes to WR; ex_c_mem_rd goes to RD. When rd and wr are both set, wr wins and rd is ignored.
REQ-021 stall = (state != IDLE) or (state == IDLE and (ex_c_mem_rd or ex_c_mem_wr)).
REQ-022 stall falls combinationally in the cycle bus_ack is sampled in RD, WR or RMW_WR.
REQ-023 bus_addr = {ex_alu_r[31:2], 2'b00}. bus_req is registered and held until bus_ack. bus_we = 1 in WR and RMW_WR only.
REQ-024 RD + bus_ack: data_word <= bus_rdata. The other outputs are captured per REQ-019. Next state IDLE.
REQ-025 WR: bus_wdata = ex_store_data. On bus_ack, return to IDLE; data_word is unchanged.
REQ-026 RMW_RD + bus_ack: latch bus_rdata and replace byte lane k = ex_alu_r[1:0] (bits 8k+7:8k) with ex_store_data[7:0]. Next state RMW_WR.
REQ-027 RMW_WR drives the merged word; on bus_ack, return to IDLE.
REQ-028 bus_ack is ignored in IDLE and whenever bus_req=0.
REQ-029 ex_* inputs are sampled while stall=1; they stay stable because upstream is stalled.

Reset
REQ-030 rst_n low forces state IDLE, bus_req=0, bus_we=0, bus_err=0 and all registered outputs to 0 immediately, without waiting for clk.
REQ-031 Reset asserted mid-transaction abandons it; no retry is made after release.
REQ-032 The first edge after release behaves as IDLE.

Configuration
REQ-033 Macro MEM_TIMEOUT_EN, when defined, adds an 8-bit wait counter:
- cleared on entry to any bus state;
- increments each cycle while bus_req=1 and bus_ack=0;
- at TMO_CYC: bus_req falls, bus_err pulses for 1 cycle, data_word <= 0, state goes to IDLE, stall falls.
REQ-034 Without MEM_TIMEOUT_EN:
- no counter is built;
- bus_err is tied to 0;
- the FSM waits for bus_ack indefinitely.

Verification
REQ-035 Non-memory op, ex_alu_r=0x1234, ex_c_wb_src=2 -> next edge: alu_r=0x1234, c_wb_src=2, stall=0.
REQ-036 lbu at address 0x103, ack after 3 cycles with rdata=0xAABBCCDD -> bus_addr=0x100, stall high 4 cycles, then data_word=0xAABBCCDD, lbu_byte=3.
REQ-037 sb at address 0x201, store_data=0x55, read returns 0x11223344 -> write cycle has bus_wdata=0x11225544, bus_we=1.
REQ-038 rd and wr both set, address 0x40 -> a single write transaction only, bus_we=1.
REQ-039 rst_n pulled low during RMW_WR -> bus_req=0 immediately; after release, state IDLE and all outputs 0.
REQ-040 With MEM_TIMEOUT_EN defined, read issued and no ack -> after 255 cycles bus_err pulses for 1 cycle, data_word=0, stall=0.

Source files
------------

// File: rtl/mem_access.sv
// ----------------------------------------------------------------------------
// mem_access -- memory stage of a small in-order pipeline.
//
// Turns load / store requests coming out of execute into single-word bus
// transactions and registers the writeback values (ALU result, link address,
// writeback select, loaded word, byte offset for lbu).
//
// Byte stores (sb) are done as read-modify-write: the addressed word is read,
// one byte lane is replaced, and the merged word is written back. Byte loads
// (lbu) read the whole word; writeback selects the byte using lbu_byte.
//
// Optional feature (macro MEM_TIMEOUT_EN): a bus watchdog that aborts a
// transaction after TMO_CYC cycles without bus_ack, pulses bus_err, forces
// data_word to zero and returns to IDLE. Without the macro no counter is
// built, bus_err is tied low and the FSM waits for bus_ack forever.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ex_alu_r            byte address for loads/stores, ALU result otherwise
//   ex_store_data       store operand (rt)
//   ex_jalra            link address
//   ex_c_wb_src         writeback source select (passed through)
//   ex_c_mem_rd/_wr     load / store request
//   ex_c_mem_byte       byte-size qualifier (lbu / sb)
//   stall               holds execute and earlier stages
//   bus_req, bus_we     bus request (held until bus_ack), write enable
//   bus_addr, bus_wdata word-aligned address, write data
//   bus_ack, bus_rdata  one-cycle completion strobe, read data with bus_ack
//   data_word           registered load data
//   jalra, alu_r        registered link address / ALU result
//   lbu_byte            registered byte offset (ex_alu_r[1:0])
//   c_wb_src            registered writeback select
//   bus_err             one-cycle watchdog abort pulse
// ----------------------------------------------------------------------------
module mem_access #(
  parameter int W_DATA  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_DATA-1:0] ex_alu_r,
  input  logic [W_DATA-1:0] ex_store_data,
  input  logic [W_DATA-1:0] ex_jalra,
  input  logic [1:0]        ex_c_wb_src,
  input  logic              ex_c_mem_rd,
  input  logic              ex_c_mem_wr,
  input  logic              ex_c_mem_byte,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [W_DATA-1:0] bus_addr,
  output logic [W_DATA-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [W_DATA-1:0] bus_rdata,
  output logic [W_DATA-1:0] data_word,
  output logic [W_DATA-1:0] jalra,
  output logic [W_DATA-1:0] alu_r,
  output logic [1:0]        lbu_byte,
  output logic [1:0]        c_wb_src,
  output logic              bus_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_bus_req;
  logic              r_bus_we;
  logic              r_bus_err;
  logic [W_DATA-1:0] r_merge;
  logic [W_DATA-1:0] r_data_word;
  logic [W_DATA-1:0] r_jalra;
  logic [W_DATA-1:0] r_alu_r;
  logic [1:0]        r_lbu_byte;
  logic [1:0]        r_c_wb_src;

  logic              w_ack;
  logic              w_done;
  logic              w_tmo;
  logic              w_stall;

  // Replace one byte lane of a word; lane 0 is bits 7:0.
  function automatic logic [W_DATA-1:0] merge_byte(
    input logic [W_DATA-1:0] word,
    input logic [1:0]        lane,
    input logic [7:0]        data
  );
    logic [W_DATA-1:0] m;
    m = word;
    case (lane)
      2'd0:    m[7:0]   = data;
      2'd1:    m[15:8]  = data;
      2'd2:    m[23:16] = data;
      default: m[31:24] = data;
    endcase
    return m;
  endfunction

  // An ack only counts while a request is outstanding.
  assign w_ack = bus_ack & r_bus_req;

  // Completion of the last bus phase of an operation (RMW_RD is not last).
  assign w_done = w_ack & ((r_state == S_RD) | (r_state == S_WR) |
                           (r_state == S_RMW_WR));

`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_wait_cnt;

  // Fires in the TMO_CYC-th consecutive cycle of waiting.
  assign w_tmo = r_bus_req & ~bus_ack & (r_wait_cnt == 8'(TMO_CYC - 1));

  // Cleared whenever a new bus phase is about to start (from IDLE, or the
  // RMW_RD -> RMW_WR hand-over), counts while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if ((r_state == S_IDLE) || w_ack) begin
      r_wait_cnt <= 8'd0;
    end else if (r_bus_req && !bus_ack) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Stall drops combinationally in the cycle the operation completes (or is
  // aborted by the watchdog) so execute can advance on the same edge.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:   w_stall = ex_c_mem_rd | ex_c_mem_wr;
      S_RMW_RD: w_stall = ~w_tmo;
      default:  w_stall = ~(w_done | w_tmo);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_err   <= 1'b0;
      r_merge     <= '0;
      r_data_word <= '0;
      r_jalra     <= '0;
      r_alu_r     <= '0;
      r_lbu_byte  <= 2'd0;
      r_c_wb_src  <= 2'd0;
    end else begin
      r_bus_err <= 1'b0;

      // Writeback values advance whenever the pipeline is not held.
      if (!w_stall) begin
        r_alu_r    <= ex_alu_r;
        r_jalra    <= ex_jalra;
        r_c_wb_src <= ex_c_wb_src;
        r_lbu_byte <= ex_alu_r[1:0];
      end

      case (r_state)
        S_IDLE: begin
          // Store has priority; a simultaneous read request is dropped.
          if (ex_c_mem_wr && ex_c_mem_byte) begin
            r_state   <= S_RMW_RD;
            r_bus_req <= 1'b1;
            r_bus_we  <= 1'b0;
          end else if (ex_c_mem_wr) begin
            r_state   <= S_WR;
            r_bus_req <= 1'b1;
            r_bus_we  <= 1'b1;
          end else if (ex_c_mem_rd) begin
            r_state   <= S_RD;
            r_bus_req <= 1'b1;
            r_bus_we  <= 1'b0;
          end
        end
        S_RD: begin
          if (w_ack) begin
            r_data_word <= bus_rdata;
            r_bus_req   <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_WR: begin
          if (w_ack) begin
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_RMW_RD: begin
          // bus_req stays high: the write phase follows back-to-back.
          if (w_ack) begin
            r_merge  <= merge_byte(bus_rdata, ex_alu_r[1:0], ex_store_data[7:0]);
            r_bus_we <= 1'b1;
            r_state  <= S_RMW_WR;
          end
        end
        S_RMW_WR: begin
          if (w_ack) begin
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_bus_req <= 1'b0;
          r_bus_we  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase

      // Watchdog abort overrides whatever the FSM was doing.
      if (w_tmo) begin
        r_bus_req   <= 1'b0;
        r_bus_we    <= 1'b0;
        r_bus_err   <= 1'b1;
        r_data_word <= '0;
        r_state     <= S_IDLE;
      end
    end
  end

  assign stall     = w_stall;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = {ex_alu_r[W_DATA-1:2], 2'b00};
  assign bus_wdata = (r_state == S_RMW_WR) ? r_merge : ex_store_data;
  assign data_word = r_data_word;
  assign jalra     = r_jalra;
  assign alu_r     = r_alu_r;
  assign lbu_byte  = r_lbu_byte;
  assign c_wb_src  = r_c_wb_src;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] ex_alu_r = '0, ex_store_data = '0, ex_jalra = '0;
  logic [1:0]  ex_c_wb_src = '0;
  logic        ex_c_mem_rd = 1'b0, ex_c_mem_wr = 1'b0, ex_c_mem_byte = 1'b0;
  logic        stall, bus_req, bus_we, bus_err;
  logic [31:0] bus_addr, bus_wdata, data_word, jalra, alu_r;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [1:0]  lbu_byte, c_wb_src;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access #(.W_DATA(32), .TMO_CYC(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_alu_r(ex_alu_r), .ex_store_data(ex_store_data), .ex_jalra(ex_jalra),
    .ex_c_wb_src(ex_c_wb_src), .ex_c_mem_rd(ex_c_mem_rd),
    .ex_c_mem_wr(ex_c_mem_wr), .ex_c_mem_byte(ex_c_mem_byte),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .data_word(data_word), .jalra(jalra), .alu_r(alu_r),
    .lbu_byte(lbu_byte), .c_wb_src(c_wb_src), .bus_err(bus_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ops();
    ex_c_mem_rd   = 1'b0;
    ex_c_mem_wr   = 1'b0;
    ex_c_mem_byte = 1'b0;
  endtask

  typedef struct {
    logic [31:0] alu;
    logic [31:0] jal;
    logic [1:0]  wb;
    logic [31:0] exp_alu;
    logic [31:0] exp_jal;
    logic [1:0]  exp_wb;
    logic [1:0]  exp_lbu;
  } vec_t;

  vec_t vt[4];
  int   cnt;

  initial begin
    vt[0] = '{32'h0000_1234, 32'h0000_0008, 2'd2, 32'h0000_1234, 32'h0000_0008, 2'd2, 2'd0};
    vt[1] = '{32'hDEAD_BEEF, 32'h1000_0004, 2'd1, 32'hDEAD_BEEF, 32'h1000_0004, 2'd1, 2'd3};
    vt[2] = '{32'h0000_0102, 32'hFFFF_FFFC, 2'd3, 32'h0000_0102, 32'hFFFF_FFFC, 2'd3, 2'd2};
    vt[3] = '{32'h8000_0001, 32'h0000_0000, 2'd0, 32'h8000_0001, 32'h0000_0000, 2'd0, 2'd1};

    // Reset state, asserted before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_data_word", data_word, 32'd0);
    chk("rst_alu_r", alu_r, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Non-memory pass-through vectors.
    for (int i = 0; i < 4; i++) begin
      ex_alu_r    = vt[i].alu;
      ex_jalra    = vt[i].jal;
      ex_c_wb_src = vt[i].wb;
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
      tick();
      chk($sformatf("v%0d_alu_r", i), alu_r, vt[i].exp_alu);
      chk($sformatf("v%0d_jalra", i), jalra, vt[i].exp_jal);
      chk($sformatf("v%0d_wb_src", i), {30'd0, c_wb_src}, {30'd0, vt[i].exp_wb});
      chk($sformatf("v%0d_lbu", i), {30'd0, lbu_byte}, {30'd0, vt[i].exp_lbu});
    end

    // lbu at 0x103, ack after three wait cycles.
    ex_alu_r = 32'h0000_0103;
    ex_c_mem_rd = 1'b1;
    ex_c_mem_byte = 1'b1;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin
        bus_ack = 1'b1;
        bus_rdata = 32'hAABB_CCDD;
      end
      @(negedge clk);
      if (c == 0) chk("lbu_req_idle", {31'd0, bus_req}, 32'd0);
      if (c == 2) chk("lbu_req_wait", {31'd0, bus_req}, 32'd1);
      if (c == 2) chk("lbu_we", {31'd0, bus_we}, 32'd0);
      if (stall) cnt++;
      tick();
    end
    bus_ack = 1'b0;
    clr_ops();
    chk("lbu_addr", bus_addr, 32'h0000_0100);
    chk("lbu_stall_cycles", cnt, 32'd4);
    chk("lbu_data", data_word, 32'hAABB_CCDD);
    chk("lbu_byte", {30'd0, lbu_byte}, 32'd3);
    chk("lbu_req_done", {31'd0, bus_req}, 32'd0);

    // Ack while idle must be ignored.
    ex_alu_r = 32'h0000_0010;
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_ack = 1'b0;
    chk("idle_ack_data", data_word, 32'hAABB_CCDD);
    chk("idle_ack_req", {31'd0, bus_req}, 32'd0);

    // sb at 0x201: read-modify-write of lane 1.
    ex_alu_r = 32'h0000_0201;
    ex_store_data = 32'hFFFF_FF55;
    ex_c_mem_wr = 1'b1;
    ex_c_mem_byte = 1'b1;
    tick();
    chk("sb_rd_req", {31'd0, bus_req}, 32'd1);
    chk("sb_rd_we", {31'd0, bus_we}, 32'd0);
    bus_ack = 1'b1;
    bus_rdata = 32'h1122_3344;
    @(negedge clk);
    chk("sb_rd_ack_stall", {31'd0, stall}, 32'd1);
    tick();
    bus_ack = 1'b0;
    bus_rdata = 32'h9999_9999;
    @(negedge clk);
    chk("sb_wr_we", {31'd0, bus_we}, 32'd1);
    chk("sb_wr_req", {31'd0, bus_req}, 32'd1);
    chk("sb_wr_data", bus_wdata, 32'h1122_5544);
    chk("sb_wr_addr", bus_addr, 32'h0000_0200);
    chk("sb_wr_stall", {31'd0, stall}, 32'd1);
    tick();
    bus_ack = 1'b1;
    @(negedge clk);
    chk("sb_ack_stall", {31'd0, stall}, 32'd0);
    tick();
    bus_ack = 1'b0;
    clr_ops();
    chk("sb_done_req", {31'd0, bus_req}, 32'd0);
    chk("sb_done_we", {31'd0, bus_we}, 32'd0);
    chk("sb_data_keep", data_word, 32'hAABB_CCDD);

    // rd and wr both set at 0x40: one plain write only.
    ex_alu_r = 32'h0000_0040;
    ex_store_data = 32'hDEAD_BEEF;
    ex_c_mem_rd = 1'b1;
    ex_c_mem_wr = 1'b1;
    tick();
    chk("rw_we", {31'd0, bus_we}, 32'd1);
    chk("rw_req", {31'd0, bus_req}, 32'd1);
    chk("rw_wdata", bus_wdata, 32'hDEAD_BEEF);
    chk("rw_addr", bus_addr, 32'h0000_0040);
    bus_ack = 1'b1;
    bus_rdata = 32'h1234_5678;
    tick();
    bus_ack = 1'b0;
    clr_ops();
    tick();
    chk("rw_single_req", {31'd0, bus_req}, 32'd0);
    chk("rw_data_keep", data_word, 32'hAABB_CCDD);

    // Reset pulled during RMW_WR.
    ex_alu_r = 32'h0000_0302;
    ex_store_data = 32'h0000_0077;
    ex_c_mem_wr = 1'b1;
    ex_c_mem_byte = 1'b1;
    tick();
    bus_ack = 1'b1;
    bus_rdata = 32'h0;
    tick();
    bus_ack = 1'b0;
    chk("rst_mid_pre_we", {31'd0, bus_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, bus_req}, 32'd0);
    chk("rst_mid_we", {31'd0, bus_we}, 32'd0);
    chk("rst_mid_data", data_word, 32'd0);
    chk("rst_mid_alu", alu_r, 32'd0);
    clr_ops();
    ex_alu_r = 32'd0;
    ex_store_data = 32'd0;
    ex_jalra = 32'd0;
    ex_c_wb_src = 2'd0;
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_req", {31'd0, bus_req}, 32'd0);
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_alu", alu_r, 32'd0);
    chk("post_rst_jalra", jalra, 32'd0);
    chk("post_rst_data", data_word, 32'd0);
    chk("post_rst_wb", {30'd0, c_wb_src}, 32'd0);
    tick();
    chk("no_retry_req", {31'd0, bus_req}, 32'd0);

    // Preload data_word, then issue a read that never gets acked.
    ex_alu_r = 32'h0000_0010;
    ex_c_mem_rd = 1'b1;
    tick();
    bus_ack = 1'b1;
    bus_rdata = 32'h5A5A_5A5A;
    tick();
    bus_ack = 1'b0;
    clr_ops();
    tick();
    chk("pre_tmo_data", data_word, 32'h5A5A_5A5A);
    ex_c_mem_rd = 1'b1;
    tick();
`ifdef MEM_TIMEOUT_EN
    cnt = 0;
    begin : tmo_wait
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (bus_req) cnt++;
        if (!stall) disable tmo_wait;
        tick();
      end
    end
    chk("tmo_req_cycles", cnt, 32'd255);
    chk("tmo_stall", {31'd0, stall}, 32'd0);
    tick();
    clr_ops();
    chk("tmo_err", {31'd0, bus_err}, 32'd1);
    chk("tmo_data", data_word, 32'd0);
    chk("tmo_req", {31'd0, bus_req}, 32'd0);
    tick();
    chk("tmo_err_pulse", {31'd0, bus_err}, 32'd0);
`else
    repeat (300) tick();
    @(negedge clk);
    chk("wait_err", {31'd0, bus_err}, 32'd0);
    chk("wait_stall", {31'd0, stall}, 32'd1);
    chk("wait_req", {31'd0, bus_req}, 32'd1);
    tick();
    bus_ack = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_ack = 1'b0;
    clr_ops();
    chk("wait_data", data_word, 32'hCAFE_F00D);
    chk("wait_done_req", {31'd0, bus_req}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
